// File: rtl/id_ex_elastic_reg_if.sv
// Valid/ready stream bundle carrying decoded payload and control between pipeline stages.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface id_ex_elastic_reg_if #(
   parameter int PAYLOAD_W = 133,
   parameter int CTRL_W    = 7
);
   logic                 valid;
   logic                 ready;
   logic [PAYLOAD_W-1:0] payload;
   logic [CTRL_W-1:0]    ctrl;

   modport master (output valid, output payload, output ctrl, input ready);
   modport slave  (input valid, input payload, input ctrl, output ready);
endinterface

// File: rtl/id_ex_elastic_reg.sv
// Decode->Execute elastic pipeline register: a main entry plus a skid entry, with a registered in_ready and a synchronous flush.
// Define STAGE_PERF_EN to add the saturating stall_cnt/bubble_cnt performance counters.
module id_ex_elastic_reg #(
   parameter int                       PAYLOAD_W   = 133,
   parameter int                       CTRL_W      = 7,
   parameter logic [PAYLOAD_W-1:0]     RESET_VALUE = '0,
   parameter logic [CTRL_W-1:0]        CTRL_BUBBLE = '0
`ifdef STAGE_PERF_EN
   , parameter int                     CNT_W       = 32
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
`ifdef STAGE_PERF_EN
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    bubble_cnt,
`endif
   id_ex_elastic_reg_if.slave  in_if,
   id_ex_elastic_reg_if.master out_if
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

   state_e               state_q, state_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic [PAYLOAD_W-1:0] main_payload_q, main_payload_d;
   logic [CTRL_W-1:0]    main_ctrl_q, main_ctrl_d;
   logic [PAYLOAD_W-1:0] skid_payload_q, skid_payload_d;
   logic [CTRL_W-1:0]    skid_ctrl_q, skid_ctrl_d;
   logic                 in_fire, out_fire;

   assign in_fire  = in_if.valid & in_ready_q;
   assign out_fire = out_valid_q & out_if.ready;

   // Flush overrides every transition; a simultaneous out_fire has already been seen by EX.
   always_comb begin
      state_d        = state_q;
      in_ready_d     = in_ready_q;
      main_payload_d = main_payload_q;
      main_ctrl_d    = main_ctrl_q;
      skid_payload_d = skid_payload_q;
      skid_ctrl_d    = skid_ctrl_q;
      unique case (state_q)
         EMPTY: begin
            in_ready_d = 1'b1;
            if (in_fire) begin
               state_d        = ONE;
               main_payload_d = in_if.payload;
               main_ctrl_d    = in_if.ctrl;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_payload_d = in_if.payload;
               main_ctrl_d    = in_if.ctrl;
            end else if (in_fire) begin
               state_d        = FULL;
               skid_payload_d = in_if.payload;
               skid_ctrl_d    = in_if.ctrl;
               in_ready_d     = 1'b0;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               state_d        = ONE;
               main_payload_d = skid_payload_q;
               main_ctrl_d    = skid_ctrl_q;
               in_ready_d     = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d        = EMPTY;
         main_payload_d = RESET_VALUE;
         main_ctrl_d    = CTRL_BUBBLE;
         in_ready_d     = 1'b1;
      end
      out_valid_d = (state_d != EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= EMPTY;
         in_ready_q     <= 1'b0;
         out_valid_q    <= 1'b0;
         main_payload_q <= RESET_VALUE;
         main_ctrl_q    <= CTRL_BUBBLE;
         skid_payload_q <= RESET_VALUE;
         skid_ctrl_q    <= CTRL_BUBBLE;
      end else begin
         state_q        <= state_d;
         in_ready_q     <= in_ready_d;
         out_valid_q    <= out_valid_d;
         main_payload_q <= main_payload_d;
         main_ctrl_q    <= main_ctrl_d;
         skid_payload_q <= skid_payload_d;
         skid_ctrl_q    <= skid_ctrl_d;
      end
   end

   assign in_if.ready    = in_ready_q;
   assign out_if.valid   = out_valid_q;
   assign out_if.payload = main_payload_q;
   assign out_if.ctrl    = out_valid_q ? main_ctrl_q : CTRL_BUBBLE;

`ifdef STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Counters saturate at all-ones and survive flush; only rst_n clears them.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (out_valid_q && !out_if.ready && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (!out_valid_q && (bubble_cnt_q != '1))
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Directed self-checking bench for id_ex_elastic_reg: reset, streaming, stall, flush, simultaneous fire, and perf counters.
// Expected values are hand-derived per step; payload/ctrl are generated from the pc so every field is checked.
module tb_id_ex_elastic_reg;

   localparam int PAYLOAD_W = 133;
   localparam int CTRL_W    = 7;

   logic clk;
   logic rst_n;
   logic flush;
   int   checks;
   int   errors;

`ifdef STAGE_PERF_EN
   logic [3:0] stall_cnt;
   logic [3:0] bubble_cnt;
`endif

   id_ex_elastic_reg_if #(.PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W)) in_if ();
   id_ex_elastic_reg_if #(.PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W)) out_if ();

   id_ex_elastic_reg #(
      .PAYLOAD_W (PAYLOAD_W),
      .CTRL_W    (CTRL_W)
`ifdef STAGE_PERF_EN
      , .CNT_W   (4)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
`ifdef STAGE_PERF_EN
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt),
`endif
      .in_if      (in_if.slave),
      .out_if     (out_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [PAYLOAD_W-1:0] mk_payload(input logic [31:0] pc);
      return {pc + 32'h1000, ~pc, pc ^ 32'hA5A5_0000, pc, pc[6:2]};
   endfunction

   function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [31:0] pc);
      return pc[8:2] ^ 7'h55;
   endfunction

   task automatic check_output(input string tag, input logic [139:0] observed, input logic [139:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_state(input string tag, input logic exp_valid, input logic exp_ready, input logic [31:0] exp_pc);
      check_output({tag, ".out_valid"}, 140'(out_if.valid), 140'(exp_valid));
      check_output({tag, ".in_ready"}, 140'(in_if.ready), 140'(exp_ready));
      if (exp_valid) begin
         check_output({tag, ".payload"}, 140'(out_if.payload), 140'(mk_payload(exp_pc)));
         check_output({tag, ".ctrl"}, 140'(out_if.ctrl), 140'(mk_ctrl(exp_pc)));
      end else begin
         check_output({tag, ".ctrl_bubble"}, 140'(out_if.ctrl), 140'(0));
      end
   endtask

   task automatic apply_stimulus(input logic valid, input logic [31:0] pc, input logic oready, input logic fl);
      in_if.valid   = valid;
      in_if.payload = mk_payload(pc);
      in_if.ctrl    = mk_ctrl(pc);
      out_if.ready  = oready;
      flush         = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
      #12;
      check_state("rst", 1'b0, 1'b0, 32'h0);
      check_output("rst.payload", 140'(out_if.payload), 140'(0));
`ifdef STAGE_PERF_EN
      check_output("rst.stall_cnt", 140'(stall_cnt), 140'(0));
      check_output("rst.bubble_cnt", 140'(bubble_cnt), 140'(0));
`endif
      rst_n = 1'b1;
      step();
      check_state("rst_release", 1'b0, 1'b1, 32'h0);

      // T2 streaming
      apply_stimulus(1'b1, 32'h00, 1'b1, 1'b0);
      step();
      check_state("t2_c1", 1'b1, 1'b1, 32'h00);
      apply_stimulus(1'b1, 32'h04, 1'b1, 1'b0);
      step();
      check_state("t2_c2", 1'b1, 1'b1, 32'h04);
      apply_stimulus(1'b1, 32'h08, 1'b1, 1'b0);
      step();
      check_state("t2_c3", 1'b1, 1'b1, 32'h08);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      check_state("t2_drain", 1'b0, 1'b1, 32'h0);

      // T3 stall
      apply_stimulus(1'b1, 32'h10, 1'b0, 1'b0);
      step();
      check_state("t3_one", 1'b1, 1'b1, 32'h10);
      apply_stimulus(1'b1, 32'h14, 1'b0, 1'b0);
      step();
      check_state("t3_full", 1'b1, 1'b0, 32'h10);
      apply_stimulus(1'b1, 32'h18, 1'b0, 1'b0);
      step();
      check_state("t3_hold", 1'b1, 1'b0, 32'h10);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      check_state("t3_pop1", 1'b1, 1'b1, 32'h14);
      step();
      check_state("t3_pop2", 1'b0, 1'b1, 32'h0);

      // T4 flush from FULL, then flush from ONE with a colliding in_fire
      apply_stimulus(1'b1, 32'h20, 1'b0, 1'b0);
      step();
      apply_stimulus(1'b1, 32'h24, 1'b0, 1'b0);
      step();
      check_state("t4_full", 1'b1, 1'b0, 32'h20);
      apply_stimulus(1'b1, 32'h28, 1'b0, 1'b1);
      step();
      check_state("t4_flush", 1'b0, 1'b1, 32'h0);
      check_output("t4_flush.payload", 140'(out_if.payload), 140'(0));
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      check_state("t4_after", 1'b0, 1'b1, 32'h0);
      apply_stimulus(1'b1, 32'h2C, 1'b0, 1'b0);
      step();
      check_state("t4_one", 1'b1, 1'b1, 32'h2C);
      apply_stimulus(1'b1, 32'h28, 1'b0, 1'b1);
      step();
      check_state("t4_flush_drop", 1'b0, 1'b1, 32'h0);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      check_state("t4_no_28", 1'b0, 1'b1, 32'h0);

      // T5 simultaneous in_fire and out_fire in ONE
      apply_stimulus(1'b1, 32'h30, 1'b1, 1'b0);
      step();
      check_state("t5_one", 1'b1, 1'b1, 32'h30);
      apply_stimulus(1'b1, 32'h34, 1'b1, 1'b0);
      step();
      check_state("t5_swap", 1'b1, 1'b1, 32'h34);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      check_state("t5_drain", 1'b0, 1'b1, 32'h0);

      // T1 mid-stream asynchronous reset with two entries held
      apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0);
      step();
      apply_stimulus(1'b1, 32'h44, 1'b0, 1'b0);
      step();
      check_state("t1_full", 1'b1, 1'b0, 32'h40);
      apply_stimulus(1'b1, 32'h50, 1'b0, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check_state("t1_async", 1'b0, 1'b0, 32'h0);
      check_output("t1_async.payload", 140'(out_if.payload), 140'(0));
      #3;
      rst_n = 1'b1;
      step();
      check_state("t1_release", 1'b0, 1'b1, 32'h0);
      step();
      check_state("t1_accept", 1'b1, 1'b1, 32'h50);

`ifdef STAGE_PERF_EN
      // T6 perf: two bubble cycles so far since reset, then three stalls, then idle to saturation
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
      step();
      step();
      step();
      check_output("t6_stall3", 140'(stall_cnt), 140'(3));
      check_output("t6_bubble2", 140'(bubble_cnt), 140'(2));
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) step();
      check_output("t6_bubble_sat", 140'(bubble_cnt), 140'(15));
      check_output("t6_stall_keep", 140'(stall_cnt), 140'(3));
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      step();
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      check_output("t6_flush_stall", 140'(stall_cnt), 140'(3));
      check_output("t6_flush_bubble", 140'(bubble_cnt), 140'(15));
`else
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      check_state("t1_drain", 1'b0, 1'b1, 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
